seq_frame_tx: RTL and testbench



---
 rtl/seq_tx_pkg.sv | 21 ++
 rtl/seq_frame_tx.sv | 108 ++++++++++
 tb/tb_seq_frame_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Definitions shared by the 1011 frame transmitter and its detector partner:
// FSM state encoding, the preamble pattern and a small sizing helper.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int PRE_W = 4;
    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1011;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: accepts a payload word over valid/ready and sends
// preamble 1011, the payload MSB first, then GAP_CYC idle zeros on tx_bit.
module seq_frame_tx #(
    parameter int         DATA_W   = 8,
    parameter int         GAP_CYC  = 2,
    parameter logic [3:0] PREAMBLE = seq_tx_pkg::PREAMBLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);
    import seq_tx_pkg::*;

    localparam int CNT_W = $clog2(max3(DATA_W, GAP_CYC, PRE_W)) + 1;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              tx_bit_q;
    logic              tx_active_q;
    logic              frame_done_q;
    logic              in_ready_q;
    logic [1:0]        pre_idx;

    // cnt_q holds the index of the preamble bit currently on the line
    assign pre_idx = cnt_q[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_bit_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= PRE;
                        shift_q     <= in_data;
                        cnt_q       <= CNT_W'(PRE_W - 1);
                        tx_bit_q    <= PREAMBLE[PRE_W-1];
                        tx_active_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt_q != '0) begin
                        cnt_q    <= cnt_q - CNT_W'(1);
                        tx_bit_q <= PREAMBLE[pre_idx];
                    end else begin
                        state_q      <= DATA;
                        cnt_q        <= CNT_W'(DATA_W - 1);
                        tx_bit_q     <= shift_q[DATA_W-1];
                        shift_q      <= shift_q << 1;
                        frame_done_q <= (DATA_W == 1);
                    end
                end
                DATA: begin
                    // cnt_q counts payload bits still to send after the current one
                    if (cnt_q != '0) begin
                        cnt_q        <= cnt_q - CNT_W'(1);
                        tx_bit_q     <= shift_q[DATA_W-1];
                        shift_q      <= shift_q << 1;
                        frame_done_q <= (cnt_q == CNT_W'(1));
                    end else begin
                        tx_bit_q    <= 1'b0;
                        tx_active_q <= 1'b0;
                        if (GAP_CYC > 0) begin
                            state_q <= GAP;
                            cnt_q   <= CNT_W'(GAP_CYC - 1);
                        end else begin
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign tx_bit     = tx_bit_q;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: scoreboard of expected line bits,
// table of payload vectors, and directed sequences for timing corner cases.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, tx_bit, tx_active, frame_done;

    logic       in_valid2;
    logic [3:0] in_data2;
    logic       in_ready2, tx_bit2, tx_active2, frame_done2;

    always #5 clk = ~clk;

    seq_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    seq_frame_tx #(.DATA_W(4), .GAP_CYC(0)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid2),
        .in_data    (in_data2),
        .in_ready   (in_ready2),
        .tx_bit     (tx_bit2),
        .tx_active  (tx_active2),
        .frame_done (frame_done2)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic b;
        logic fd;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [11:0] frame;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [11:0] fr);
        exp_t e;
        for (int i = 11; i >= 0; i--) begin
            e.b  = fr[i];
            e.fd = (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    // Offer one payload; returns in cycle 1 of the frame.
    task automatic send(input logic [7:0] d, input logic [11:0] fr);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        push_frame(fr);
        cyc();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Scoreboard: every active bit must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_active === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("tx_bit", {31'd0, tx_bit}, {31'd0, e.b});
                    chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                end
            end else begin
                chk("idle_line", {30'd0, tx_bit, frame_done}, 32'd0);
            end
        end
    end

    // Reference non-overlapping 1011 detector, Mealy output.
    typedef enum logic [1:0] {D0, D1, D10, D101} det_t;
    det_t det_q;
    logic det_z;
    assign det_z = (det_q == D101) && tx_bit;

    always @(posedge clk) begin
        if (rst) det_q <= D0;
        else begin
            case (det_q)
                D0:   det_q <= tx_bit ? D1 : D0;
                D1:   det_q <= tx_bit ? D1 : D10;
                D10:  det_q <= tx_bit ? D101 : D0;
                D101: det_q <= tx_bit ? D0 : D10;
                default: det_q <= D0;
            endcase
        end
    end

    initial begin
        vec_t vecs[7];
        int fd_at, fd_n, rdy_at, act_n, k, z_hits, z_at;
        logic [7:0] pat2;

        vecs[0] = '{8'hA5, 12'hBA5};
        vecs[1] = '{8'hFF, 12'hBFF};
        vecs[2] = '{8'h00, 12'hB00};
        vecs[3] = '{8'hC3, 12'hBC3};
        vecs[4] = '{8'h80, 12'hB80};
        vecs[5] = '{8'h01, 12'hB01};
        vecs[6] = '{8'h3C, 12'hB3C};

        // Reset held with in_valid asserted
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        in_valid2 = 1'b0; in_data2 = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_bit", {31'd0, tx_bit}, 32'd0);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        cyc();
        chk("rst_no_accept", {31'd0, tx_active}, 32'd0);
        chk("rst_ready_after", {31'd0, in_ready}, 32'd1);
        mon_en = 1'b1;

        // Single frame A5: timing of frame_done, tx_active and in_ready
        send(8'hA5, 12'hBA5);
        fd_at = 0; fd_n = 0; rdy_at = 0; act_n = 0;
        for (int c = 1; c <= 15; c++) begin
            if (frame_done === 1'b1) begin fd_at = c; fd_n++; end
            if (in_ready === 1'b1 && rdy_at == 0) rdy_at = c;
            if (tx_active === 1'b1) act_n++;
            if (c != 15) cyc();
        end
        chk("a5_done_cycle", 32'(fd_at), 32'd12);
        chk("a5_done_count", 32'(fd_n), 32'd1);
        chk("a5_ready_cycle", 32'(rdy_at), 32'd15);
        chk("a5_active_len", 32'(act_n), 32'd12);

        // Table of payloads with random idle spacing
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, 3)) cyc();
            send(vecs[i].data, vecs[i].frame);
        end
        repeat (20) cyc();

        // Back-to-back with in_valid held high
        wait_ready();
        in_valid = 1'b1; in_data = 8'hFF;
        push_frame(12'hBFF);
        cyc();
        in_data = 8'h00;
        push_frame(12'hB00);
        k = 1;
        while (in_ready !== 1'b1 && k < 40) begin
            cyc();
            k++;
        end
        chk("b2b_period", 32'(k), 32'd15);
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();

        // Loopback into the 1011 detector
        send(8'h00, 12'hB00);
        z_hits = 0; z_at = 0;
        for (int c = 1; c <= 14; c++) begin
            if (det_z === 1'b1) begin z_hits++; z_at = c; end
            cyc();
        end
        chk("loop_z_count", 32'(z_hits), 32'd1);
        chk("loop_z_cycle", 32'(z_at), 32'd4);
        repeat (5) cyc();

        // Mid-frame reset, then a clean frame
        send(8'hC3, 12'hBC3);
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        exp_q.delete();
        chk("mid_rst_tx_bit", {31'd0, tx_bit}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_active", {31'd0, tx_active}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_no_resume", {31'd0, tx_active}, 32'd0);
        send(8'hC3, 12'hBC3);
        repeat (20) cyc();

        // DATA_W=4, GAP_CYC=0 build
        pat2 = 8'hB9;
        in_valid2 = 1'b1; in_data2 = 4'h9;
        cyc();
        in_valid2 = 1'b0; in_data2 = 4'h6;
        for (int c = 1; c <= 8; c++) begin
            chk("w4_bit", {31'd0, tx_bit2}, {31'd0, pat2[8-c]});
            chk("w4_done", {31'd0, frame_done2}, {31'd0, (c == 8)});
            chk("w4_active", {31'd0, tx_active2}, 32'd1);
            cyc();
        end
        chk("w4_ready_c9", {31'd0, in_ready2}, 32'd1);
        chk("w4_idle_c9", {31'd0, tx_active2}, 32'd0);

        repeat (5) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
